rotate_word_aligner: RTL and testbench
======================================

Name: rotate_word_aligner

Overview:
Receive-side counterpart of our 4-bit rotator datapath. The transmitter right-rotates each word by an unknown, fixed shamt. This block finds that shamt by hunting for a framing sync word. It then confirms the frame alignment and streams derotated (left-rotated by shamt) words downstream, marking start of frame and flagging lock.

Parameters:
WIDTH, 4, data word width in bits; SHW = $clog2(WIDTH).
SYNC, 4'b1011, sync word before rotation; must have WIDTH distinct rotations.
FRAME_LEN, 8, words per frame, sync included; sync is word index 0.
LOCK_CNT, 2, consecutive confirmed syncs needed in VERIFY to enter LOCKED.
LOSS_CNT, 2, consecutive missed syncs in LOCKED that force a return to SEARCH.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  in_data valid this cycle
in_data  in  WIDTH  rotated word from the link
out_valid  out  1  out_data valid (only while lock path active)
out_data  out  WIDTH  derotated word
out_sof  out  1  out_data is the frame-start (sync position) word
locked  out  1  state is LOCKED
shamt  out  SHW  current rotation estimate

Behaviour:
- Reset (async, takes effect immediately, also mid-frame): state=SEARCH, shamt=0, word_cnt=0, good_cnt=0, miss_cnt=0. All outputs are 0.
- No state, counter or output update happens in any cycle with in_valid=0. out_valid is 0 in that cycle.
- rotl(x,k) = x left-rotated by k; it undoes the transmitter's right rotation. Example: rotl(4'b1101,1)=4'b1011.
- SEARCH:
  - Each valid word is compared in parallel against rotl(in_data,k) for k=0..WIDTH-1.
  - On any match, the lowest matching k is loaded into shamt, word_cnt is set to 1, good_cnt to 0, and the state moves to VERIFY.
  - With no match, the block stays in SEARCH.
  - out_valid stays 0.
- VERIFY:
  - word_cnt increments per valid word and wraps FRAME_LEN-1 -> 0.
  - When a word arrives with word_cnt==0, check rotl(in_data,shamt)==SYNC.
    - Match: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED with miss_cnt=0.
    - Mismatch: go to SEARCH. A false sync is rejected this way.
  - out_valid stays 0 in VERIFY.
- LOCKED:
  - Every valid word is emitted as rotl(in_data,shamt).
  - At word_cnt==0:
    - Match: miss_cnt=0.
    - Mismatch: miss_cnt++. If miss_cnt reaches LOSS_CNT, go to SEARCH and do not emit that word. Otherwise emit it (flywheel).
  - out_sof=1 on every emitted word with word_cnt==0.
- The LOCK_CNT-th confirming sync is itself emitted with out_sof=1.
- Outputs are registered: a word accepted at edge N appears at edge N+1, and locked changes on that same edge.
- shamt holds its value except when loaded in SEARCH.
- Simultaneous events have none beyond the above; there is no backpressure.

Decomposition:
- Package rotate_align_pkg holds:
  - state enum {SEARCH, VERIFY, LOCKED};
  - function rotl(x,k);
  - parameter defaults.
- One sub-module is natural: rotl_n, a combinational parametric left rotator (data, amount -> rotated). It is instantiated once for the datapath. The SEARCH compare is a generate loop over rotl.

Test Plan:
- Reset then idle -> all outputs 0, shamt=0. Assert reset mid-LOCKED -> locked=0, out_valid=0 immediately.
- Transmitter shamt=1 (sync on wire = 4'b1101), data words 4'b0000/4'b1111, 3 frames -> shamt=1. locked rises one cycle after the 3rd sync. That sync is output as 4'b1011 with out_sof=1. Following words are derotated correctly.
- shamt=3 (sync on wire 4'b0111) and shamt=2 (4'b1110) -> shamt=3 and shamt=2 respectively. Out words equal the original data.
- False sync: a data word 4'b1101 at index 3 in SEARCH, real syncs at index 0 -> VERIFY rejects at the next sync position and returns to SEARCH. The block still locks later, and the bench checks no out_valid before lock.
- In LOCKED, corrupt 1 sync -> stays locked, word emitted with out_sof=1. Corrupt 2 consecutive syncs -> 2nd is not emitted, locked drops, state is SEARCH.
- Random in_valid gaps (about 50% duty) during lock acquisition -> same lock point in valid-word count, and no output in gap cycles.

Source files
------------

// File: rtl/rotate_word_aligner_pkg.sv
// rtl/rotate_word_aligner_pkg.sv - shared types, defaults and rotate helper for the word aligner
package rotate_align_pkg;

  localparam int                   DEF_WIDTH     = 4;
  localparam logic [DEF_WIDTH-1:0] DEF_SYNC      = 4'b1011;
  localparam int                   DEF_FRAME_LEN = 8;
  localparam int                   DEF_LOCK_CNT  = 2;
  localparam int                   DEF_LOSS_CNT  = 2;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Undoes a transmitter right-rotation of k positions.
  function automatic logic [DEF_WIDTH-1:0] rotl(input logic [DEF_WIDTH-1:0] x,
                                                input int unsigned k);
    logic [DEF_WIDTH-1:0] r;
    for (int i = 0; i < DEF_WIDTH; i++) begin
      r[i] = x[(i + DEF_WIDTH - int'(k % DEF_WIDTH)) % DEF_WIDTH];
    end
    return r;
  endfunction

endpackage

// File: rtl/rotate_word_aligner_if.sv
// rtl/rotate_word_aligner_if.sv - link-side input and derotated output bundle
interface rotate_word_aligner_if #(
  parameter  int WIDTH = 4,
  localparam int SHW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sof;
  logic             locked;
  logic [SHW-1:0]   shamt;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_sof, locked, shamt
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_sof, locked, shamt
  );
endinterface

// File: rtl/rotate_word_aligner_rotl_n.sv
// rtl/rotate_word_aligner_rotl_n.sv - combinational parametric left rotator
module rotl_n #(
  parameter  int WIDTH = 4,
  localparam int SHW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amount_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      data_o[i] = data_i[(i + WIDTH - int'(amount_i)) % WIDTH];
    end
  end

endmodule

// File: rtl/rotate_word_aligner.sv
// rtl/rotate_word_aligner.sv - hunts the link rotation via a sync word, verifies framing
// and streams derotated words once locked.
module rotate_word_aligner
  import rotate_align_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC      = DEF_SYNC,
  parameter int               FRAME_LEN = DEF_FRAME_LEN,
  parameter int               LOCK_CNT  = DEF_LOCK_CNT,
  parameter int               LOSS_CNT  = DEF_LOSS_CNT
) (
  input logic                  clk,
  input logic                  reset,
  rotate_word_aligner_if.slave bus
);

  localparam int SHW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WCW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CMAX  = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [1:0] S_SEARCH = SEARCH;
  localparam logic [1:0] S_VERIFY = VERIFY;
  localparam logic [1:0] S_LOCKED = LOCKED;

  logic [1:0]       state_q, state_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [CW-1:0]    good_cnt_q, good_cnt_d;
  logic [CW-1:0]    miss_cnt_q, miss_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_sof_q, out_sof_d;

  logic [WIDTH-1:0] cand [WIDTH];
  logic [WIDTH-1:0] hit;
  logic             hit_any;
  logic [SHW-1:0]   hit_k;
  logic [WIDTH-1:0] derot;
  logic             sync_ok;
  logic             at_sof;
  logic [WCW-1:0]   wc_next;

  // Every candidate rotation is tried at once while hunting.
  for (genvar k = 0; k < WIDTH; k++) begin : g_cand
    rotl_n #(.WIDTH(WIDTH)) u_cand (
      .data_i   (bus.in_data),
      .amount_i (SHW'(k)),
      .data_o   (cand[k])
    );
    assign hit[k] = (cand[k] == SYNC);
  end

  always_comb begin
    hit_any = |hit;
    hit_k   = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (hit[k]) hit_k = SHW'(k);
    end
  end

  rotl_n #(.WIDTH(WIDTH)) u_derot (
    .data_i   (bus.in_data),
    .amount_i (shamt_q),
    .data_o   (derot)
  );

  assign sync_ok = (derot == SYNC);
  assign at_sof  = (word_cnt_q == '0);
  assign wc_next = (word_cnt_q == WCW'(FRAME_LEN - 1)) ? '0 : word_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    shamt_d     = shamt_q;
    word_cnt_d  = word_cnt_q;
    good_cnt_d  = good_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sof_d   = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        S_SEARCH: begin
          if (hit_any) begin
            shamt_d    = hit_k;
            word_cnt_d = WCW'(1);
            good_cnt_d = '0;
            state_d    = S_VERIFY;
          end
        end
        S_VERIFY: begin
          word_cnt_d = wc_next;
          if (at_sof) begin
            if (sync_ok) begin
              good_cnt_d = good_cnt_q + 1'b1;
              // The confirming sync that completes lock is already a valid output word.
              if (good_cnt_q == CW'(LOCK_CNT - 1)) begin
                state_d     = S_LOCKED;
                miss_cnt_d  = '0;
                out_valid_d = 1'b1;
                out_data_d  = derot;
                out_sof_d   = 1'b1;
              end
            end else begin
              state_d = S_SEARCH;
            end
          end
        end
        S_LOCKED: begin
          word_cnt_d  = wc_next;
          out_valid_d = 1'b1;
          out_data_d  = derot;
          out_sof_d   = at_sof;
          if (at_sof) begin
            if (sync_ok) begin
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
              if (miss_cnt_q == CW'(LOSS_CNT - 1)) begin
                state_d     = S_SEARCH;
                out_valid_d = 1'b0;
                out_sof_d   = 1'b0;
                out_data_d  = out_data_q;
              end
            end
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_SEARCH;
      shamt_q     <= '0;
      word_cnt_q  <= '0;
      good_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shamt_q     <= shamt_d;
      word_cnt_q  <= word_cnt_d;
      good_cnt_q  <= good_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.locked    = (state_q == S_LOCKED);
  assign bus.shamt     = shamt_q;

endmodule

// File: tb/tb_rotate_word_aligner.sv
// tb/tb_rotate_word_aligner.sv - directed table-driven bench for rotate_word_aligner
module tb_rotate_word_aligner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rotate_word_aligner_if #(.WIDTH(4)) bus ();

  rotate_word_aligner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       eov;
    logic [3:0] eod;
    logic       esof;
    logic       elock;
    logic [1:0] esh;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] plain [8];
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [3:0] d, input logic eov, input logic [3:0] eod,
                     input logic esof, input logic elock, input logic [1:0] esh);
    vec_t t;
    t.v = v; t.d = d; t.eov = eov; t.eod = eod; t.esof = esof; t.elock = elock; t.esh = esh;
    tbl.push_back(t);
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    bus.in_valid = t.v;
    bus.in_data  = t.d;
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 8'(bus.out_valid), 8'(t.eov));
    chk({tag, ".locked"},    8'(bus.locked),    8'(t.elock));
    chk({tag, ".shamt"},     8'(bus.shamt),     8'(t.esh));
    if (t.eov) begin
      chk({tag, ".out_data"}, 8'(bus.out_data), 8'(t.eod));
      chk({tag, ".out_sof"},  8'(bus.out_sof),  8'(t.esof));
    end
  endtask

  task automatic run_table(input string tag);
    for (int n = 0; n < tbl.size(); n++) apply(tbl[n], $sformatf("%s[%0d]", tag, n));
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Wire stream for a link rotated by sh: sync and data word 0001 appear rotated, the rest are invariant.
  task automatic add_lock_stream(input logic [3:0] sync_w, input logic [3:0] d3_w,
                                 input logic [1:0] sh, input int nwords);
    for (int n = 0; n < nwords; n++) begin
      int         i;
      logic [3:0] w;
      i = n % 8;
      w = (i == 0) ? sync_w : (i == 3) ? d3_w : plain[i];
      add(1'b1, w, n >= 16, plain[i], i == 0, n >= 16, sh);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 4'b0000;
    plain = '{4'b1011, 4'b0000, 4'b1111, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 4'b1111};

    do_reset();
    #1;
    chk("rst.out_valid", 8'(bus.out_valid), 8'h0);
    chk("rst.out_data",  8'(bus.out_data),  8'h0);
    chk("rst.out_sof",   8'(bus.out_sof),   8'h0);
    chk("rst.locked",    8'(bus.locked),    8'h0);
    chk("rst.shamt",     8'(bus.shamt),     8'h0);
    for (int n = 0; n < 3; n++) add(1'b0, 4'b1101, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    run_table("idle");

    add_lock_stream(4'b1101, 4'b1000, 2'd1, 25);
    run_table("sh1");
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_rst.locked",    8'(bus.locked),    8'h0);
    chk("async_rst.out_valid", 8'(bus.out_valid), 8'h0);
    chk("async_rst.out_sof",   8'(bus.out_sof),   8'h0);
    chk("async_rst.shamt",     8'(bus.shamt),     8'h0);
    do_reset();

    add_lock_stream(4'b0111, 4'b0010, 2'd3, 24);
    run_table("sh3");
    do_reset();
    add_lock_stream(4'b1110, 4'b0100, 2'd2, 24);
    run_table("sh2");

    // Stream starts mid-frame; data word 1101 at index 3 looks like a sync under shamt=1.
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      int         i;
      logic [3:0] w;
      i = n % 8;
      w = (n == 3) ? 4'b1101 : (i == 0) ? 4'b1101 : (i == 3) ? 4'b1000 : plain[i];
      add(1'b1, w, n == 32, plain[i], n == 32, n == 32, (n >= 3) ? 2'd1 : 2'd0);
    end
    run_table("false_sync");

    // Flywheel: misses at frames 3, 5 and 6; only the second consecutive miss drops lock.
    do_reset();
    add_lock_stream(4'b1101, 4'b1000, 2'd1, 24);
    for (int n = 24; n <= 48; n++) begin
      int         i;
      int         f;
      logic       bad;
      logic [3:0] w;
      i   = n % 8;
      f   = n / 8;
      bad = (i == 0) && (f == 3 || f == 5 || f == 6);
      w   = bad ? 4'b0000 : (i == 0) ? 4'b1101 : (i == 3) ? 4'b1000 : plain[i];
      add(1'b1, w, n != 48, bad ? 4'b0000 : plain[i], i == 0, n != 48, 2'd1);
    end
    add(1'b1, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3);
    run_table("loss");

    do_reset();
    add_lock_stream(4'b1101, 4'b1000, 2'd1, 24);
    for (int n = 0; n < 24; n++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 4'($urandom_range(0, 15));
        @(posedge clk);
        #1;
        chk($sformatf("gap[%0d].out_valid", n), 8'(bus.out_valid), 8'h0);
        chk($sformatf("gap[%0d].locked", n),    8'(bus.locked),    8'(n > 16));
        chk($sformatf("gap[%0d].shamt", n),     8'(bus.shamt),     8'((n >= 1) ? 1 : 0));
      end
      apply(tbl[n], $sformatf("gapw[%0d]", n));
    end
    tbl.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
